riscv_lsu: RTL
==============

// Module: riscv_lsu
// PURPOSE
//  Load-store unit: executes memory transactions requested by the core's decoded
//  mem_req/mem_we/mem_size controls. Sits between the core datapath and the
//  32-bit data memory. Stalls the core until the access completes, and generates
//  byte enables and replicated write data. Sign/zero-extends and aligns load data.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for mem_ready_i before abort; 0 = never abort
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_ni        in   1   reset, asynchronous, active-low
//  core_req_i    in   1   access requested (decoder mem_req); held stable while core_stall_o=1
//  core_we_i     in   1   1 = store, 0 = load
//  core_size_i   in   3   LDST_B/H/W/BU/HU (riscv_pkg encoding = funct3)
//  core_addr_i   in   32  byte address (ALU result)
//  core_wd_i     in   32  store data (rs2)
//  core_rd_o     out  32  extended load data; valid in DONE cycle, held afterwards
//  core_stall_o  out  1   core must freeze PC/regfile
//  core_fault_o  out  1   1-cycle pulse in DONE: timeout or misaligned access
//  mem_req_o     out  1   memory request, registered
//  mem_we_o      out  1   memory write, registered
//  mem_be_o      out  4   byte enables, registered
//  mem_addr_o    out  32  word-aligned address {addr[31:2],2'b00}, registered
//  mem_wd_o      out  32  replicated write data, registered
//  mem_rd_i      in   32  memory read word
//  mem_ready_i   in   1   memory completes request this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all mem_* outputs, core_rd_o, core_fault_o, timeout counter = 0.
//  core_stall_o = core_req_i && state!=DONE (combinational).
//  FSM IDLE->BUSY->DONE->IDLE:
//   IDLE: on core_req_i, latch size/addr[1:0]/we; register mem_* fields; go to BUSY.
//   BUSY: mem_req_o=1, fields stable. On mem_ready_i: for a load, capture the
//         extended data into core_rd_o; drop mem_req_o; go to DONE.
//         The counter increments each BUSY cycle. On reaching TIMEOUT_CYCLES
//         without ready: drop mem_req_o, fault, go to DONE.
//   DONE: exactly 1 cycle, stall released; go to IDLE. A new request is accepted
//         only from IDLE, never back-to-back from DONE.
//  Latency: min 3 cycles from request to stall release (ready in first BUSY cycle).
//  Store: core_rd_o unchanged.
//  Write: B  be=4'b0001<<addr[1:0], wd={4{wd[7:0]}}
//         H  be=addr[1]?4'b1100:4'b0011, wd={2{wd[15:0]}}
//         W  be=4'b1111
//  Read:  B/BU select byte addr[1:0], sign/zero-extend
//         H/HU select half addr[1], sign/zero-extend
//         W pass-through
//  Undefined size codes (3'b011/110/111) are treated as W.
//  mem_ready_i outside BUSY is ignored.
//  core_req_i dropped during BUSY: the transaction still completes; DONE occurs normally.
//  Async reset mid-BUSY: the request is abandoned immediately and mem_req_o=0.
// CONFIGURATION
//  `LSU_MISALIGN_EN defined:
//   - Misaligned cases: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   - In IDLE, go straight to DONE with core_fault_o=1; no memory request.
//   - core_rd_o unchanged.
//  Undefined: no check is made. Low address bits beyond the access size are ignored
//   (H uses addr[1] only; W ignores addr[1:0]).
//  core_fault_o then pulses only on timeout.
// STRUCTURE
//  riscv_pkg additions:
//   - lsu_state_t enum {LSU_IDLE, LSU_BUSY, LSU_DONE}.
//   - Reuse existing LDST_* constants.
//  Sub-module lsu_rdata_ext: combinational (mem_rd_i, size, addr[1:0]) -> extended word.
// TESTING
//  LB at addr 0x103, mem_rd=0x80FF_1234, ready in 1st BUSY -> core_rd=0xFFFF_FF80, stall 3 cycles
//  LHU at 0x102, mem_rd=0x9ABC_5678 -> core_rd=0x0000_9ABC; LH same -> 0xFFFF_9ABC
//  SB at 0x201, wd=0x1122_33AB -> mem_be=0010, mem_wd=0xABAB_ABAB, mem_addr=0x200
//  SW with ready delayed 5 cycles -> mem_req held 5+1 cycles; stall released only in DONE
//  TIMEOUT_CYCLES=4, ready never -> 4 BUSY cycles, fault pulse, mem_req_o drops; reset mid-BUSY -> all 0
//  LSU_MISALIGN_EN: LW at 0x102 -> no mem_req, fault pulse; undefined: mem_addr=0x100, be=1111

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared encodings and helpers for the load-store unit: access-size codes
// (funct3), FSM state type and byte-lane / misalignment helpers.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        LSU_WIDTH_B = 2'd0,
        LSU_WIDTH_H = 2'd1,
        LSU_WIDTH_W = 2'd2
    } lsu_width_t;

    // Undefined size codes fall through to a full-word access.
    function automatic lsu_width_t lsu_width(input logic [2:0] size);
        case (size)
            LDST_B, LDST_BU: lsu_width = LSU_WIDTH_B;
            LDST_H, LDST_HU: lsu_width = LSU_WIDTH_H;
            default:         lsu_width = LSU_WIDTH_W;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] addr_lo);
        case (lsu_width(size))
            LSU_WIDTH_B: lsu_be = 4'b0001 << addr_lo;
            LSU_WIDTH_H: lsu_be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:     lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wd);
        case (lsu_width(size))
            LSU_WIDTH_B: lsu_wdata = {4{wd[7:0]}};
            LSU_WIDTH_H: lsu_wdata = {2{wd[15:0]}};
            default:     lsu_wdata = wd;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (lsu_width(size))
            LSU_WIDTH_H: lsu_misaligned = addr_lo[0];
            LSU_WIDTH_W: lsu_misaligned = (addr_lo != 2'b00);
            default:     lsu_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load-store unit (master) and the 32-bit memory (slave).
interface riscv_lsu_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (output req, we, be, addr, wd, input rd, ready);
    modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_lsu_rdata_ext.sv
// Load-data aligner: picks the addressed byte/half of the memory word and
// sign- or zero-extends it according to the access size.
module riscv_lsu_rdata_ext
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rd >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            LDST_B:  ext = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: ext = {24'h0, byte_sel};
            LDST_H:  ext = {{16{half_sel[15]}}, half_sel};
            LDST_HU: ext = {16'h0, half_sel};
            default: ext = rd;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: one data-memory access per core request, stalling the core until
// it completes. Misaligned-access trapping is enabled with `define LSU_MISALIGN_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// LSU_IDLE | waiting for core_req_i; bus fields registered on accept
// LSU_BUSY | mem.req high, fields stable, waiting for mem.ready or timeout
// LSU_DONE | one cycle: stall released, load data / fault presented
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    riscv_lsu_if.master mem
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t       state_q, state_d;
    logic [2:0]       size_q;
    logic [1:0]       addr_lo_q;
    logic             we_q;
    logic [CNT_W-1:0] busy_cnt_q;
    logic [31:0]      rd_ext;
    logic             misalign;
    logic             timeout_hit;
    logic             accept, busy_end, fault_set, load_capture;

`ifdef LSU_MISALIGN_EN
    assign misalign = lsu_misaligned(core_size_i, core_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Counter holds the number of BUSY cycles already spent; the last allowed one aborts.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (busy_cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= LSU_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (core_req_i) state_d = misalign ? LSU_DONE : LSU_BUSY;
            LSU_BUSY: if (mem.ready || timeout_hit) state_d = LSU_DONE;
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        core_stall_o = core_req_i && (state_q != LSU_DONE);
        accept       = (state_q == LSU_IDLE) && core_req_i && !misalign;
        busy_end     = (state_q == LSU_BUSY) && (mem.ready || timeout_hit);
        load_capture = (state_q == LSU_BUSY) && mem.ready && !we_q;
        fault_set    = ((state_q == LSU_IDLE) && core_req_i && misalign) ||
                       ((state_q == LSU_BUSY) && !mem.ready && timeout_hit);
    end

    riscv_lsu_rdata_ext u_rdata_ext (
        .rd      (mem.rd),
        .size    (size_q),
        .addr_lo (addr_lo_q),
        .ext     (rd_ext)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            size_q       <= 3'b000;
            addr_lo_q    <= 2'b00;
            we_q         <= 1'b0;
            busy_cnt_q   <= '0;
            core_rd_o    <= 32'h0;
            core_fault_o <= 1'b0;
            mem.req      <= 1'b0;
            mem.we       <= 1'b0;
            mem.be       <= 4'h0;
            mem.addr     <= 32'h0;
            mem.wd       <= 32'h0;
        end else begin
            core_fault_o <= fault_set;
            if (accept) begin
                size_q     <= core_size_i;
                addr_lo_q  <= core_addr_i[1:0];
                we_q       <= core_we_i;
                busy_cnt_q <= '0;
                mem.req    <= 1'b1;
                mem.we     <= core_we_i;
                mem.be     <= lsu_be(core_size_i, core_addr_i[1:0]);
                mem.addr   <= {core_addr_i[31:2], 2'b00};
                mem.wd     <= lsu_wdata(core_size_i, core_wd_i);
            end else if (state_q == LSU_BUSY) begin
                busy_cnt_q <= busy_cnt_q + 1'b1;
                if (busy_end) mem.req <= 1'b0;
            end
            if (load_capture) core_rd_o <= rd_ext;
        end
    end

endmodule
